// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall detection, flush squashing,
// same-cycle WB bypass into captured operands and saturating stall/flush counters.
module id_ex_hazard_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [XLEN-1:0]   i_id_rs1_data,
  input  logic [XLEN-1:0]   i_id_rs2_data,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_mem_write,
  input  logic              i_id_mem_to_reg,
  input  logic              i_id_alu_src,
  input  logic [3:0]        i_id_alu_op,
  input  logic              i_id_branch,
  input  logic              i_ex_flush,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_rs1_data,
  output logic [XLEN-1:0]   o_ex_rs2_data,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [REG_AW-1:0] o_ex_rs1,
  output logic [REG_AW-1:0] o_ex_rs2,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic              o_ex_uses_rs1,
  output logic              o_ex_uses_rs2,
  output logic              o_ex_reg_write,
  output logic              o_ex_mem_read,
  output logic              o_ex_mem_write,
  output logic              o_ex_mem_to_reg,
  output logic              o_ex_alu_src,
  output logic [3:0]        o_ex_alu_op,
  output logic              o_ex_branch,
  output logic              o_pc_write_en,
  output logic              o_if_id_write_en,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_rs1_data;
  logic [XLEN-1:0]   r_ex_rs2_data;
  logic [XLEN-1:0]   r_ex_imm;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_uses_rs1;
  logic              r_ex_uses_rs2;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;
  logic              r_ex_mem_to_reg;
  logic              r_ex_alu_src;
  logic [3:0]        r_ex_alu_op;
  logic              r_ex_branch;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_hazard;
  logic              w_rs1_match;
  logic              w_rs2_match;
  logic              w_byp_rs1;
  logic              w_byp_rs2;
  logic              w_ld_ctrl;

  assign w_rs1_match = i_id_uses_rs1 && (i_id_rs1 == r_ex_rd);
  assign w_rs2_match = i_id_uses_rs2 && (i_id_rs2 == r_ex_rd);

  // Gated by reset so the stall outputs are released while reset is held,
  // even before the EX register has been cleared.
  assign w_hazard = !i_reset && r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) &&
                    i_id_valid && !i_ex_flush && (w_rs1_match || w_rs2_match);

  assign w_byp_rs1 = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_id_rs1);
  assign w_byp_rs2 = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_id_rs2);
  assign w_ld_ctrl = i_id_valid;

  assign o_pc_write_en    = !w_hazard;
  assign o_if_id_write_en = !w_hazard;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_valid      <= 1'b0;
      r_ex_pc         <= '0;
      r_ex_rs1_data   <= '0;
      r_ex_rs2_data   <= '0;
      r_ex_imm        <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
      r_ex_uses_rs1   <= 1'b0;
      r_ex_uses_rs2   <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_alu_op     <= '0;
      r_ex_branch     <= 1'b0;
    end else if (i_ex_flush || w_hazard) begin
      // Bubble: kill state-changing controls, keep datapath fields as they were.
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_branch    <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
    end else begin
      r_ex_valid      <= i_id_valid;
      r_ex_pc         <= i_id_pc;
      r_ex_rs1_data   <= w_byp_rs1 ? i_wb_data : i_id_rs1_data;
      r_ex_rs2_data   <= w_byp_rs2 ? i_wb_data : i_id_rs2_data;
      r_ex_imm        <= i_id_imm;
      r_ex_uses_rs1   <= i_id_uses_rs1;
      r_ex_uses_rs2   <= i_id_uses_rs2;
      r_ex_mem_to_reg <= i_id_mem_to_reg;
      r_ex_alu_src    <= i_id_alu_src;
      r_ex_alu_op     <= i_id_alu_op;
      r_ex_rs1        <= w_ld_ctrl ? i_id_rs1 : '0;
      r_ex_rs2        <= w_ld_ctrl ? i_id_rs2 : '0;
      r_ex_rd         <= w_ld_ctrl ? i_id_rd : '0;
      r_ex_reg_write  <= w_ld_ctrl && i_id_reg_write;
      r_ex_mem_read   <= w_ld_ctrl && i_id_mem_read;
      r_ex_mem_write  <= w_ld_ctrl && i_id_mem_write;
      r_ex_branch     <= w_ld_ctrl && i_id_branch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_ex_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_ex_valid      = r_ex_valid;
  assign o_ex_pc         = r_ex_pc;
  assign o_ex_rs1_data   = r_ex_rs1_data;
  assign o_ex_rs2_data   = r_ex_rs2_data;
  assign o_ex_imm        = r_ex_imm;
  assign o_ex_rs1        = r_ex_rs1;
  assign o_ex_rs2        = r_ex_rs2;
  assign o_ex_rd         = r_ex_rd;
  assign o_ex_uses_rs1   = r_ex_uses_rs1;
  assign o_ex_uses_rs2   = r_ex_uses_rs2;
  assign o_ex_reg_write  = r_ex_reg_write;
  assign o_ex_mem_read   = r_ex_mem_read;
  assign o_ex_mem_write  = r_ex_mem_write;
  assign o_ex_mem_to_reg = r_ex_mem_to_reg;
  assign o_ex_alu_src    = r_ex_alu_src;
  assign o_ex_alu_op     = r_ex_alu_op;
  assign o_ex_branch     = r_ex_branch;
  assign o_stall_cnt     = r_stall_cnt;
  assign o_flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: a default-width instance and a CNT_W=4
// instance share all stimulus so counter saturation can be reached quickly.
module tb_id_ex_hazard_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_alu_src, id_branch;
  logic [3:0]  id_alu_op;
  logic        ex_flush, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        ex_valid, ex_uses_rs1, ex_uses_rs2, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_alu_src, ex_branch, pc_write_en, if_id_write_en;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid, s_uses_rs1, s_uses_rs2, s_reg_write, s_mem_read, s_mem_write;
  logic        s_mem_to_reg, s_alu_src, s_branch, s_pc_we, s_ifid_we;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_alu_op;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage dut (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read), .i_id_mem_write(id_mem_write),
    .i_id_mem_to_reg(id_mem_to_reg), .i_id_alu_src(id_alu_src), .i_id_alu_op(id_alu_op),
    .i_id_branch(id_branch), .i_ex_flush(ex_flush), .i_wb_reg_write(wb_reg_write),
    .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs1_data(ex_rs1_data),
    .o_ex_rs2_data(ex_rs2_data), .o_ex_imm(ex_imm), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2),
    .o_ex_rd(ex_rd), .o_ex_uses_rs1(ex_uses_rs1), .o_ex_uses_rs2(ex_uses_rs2),
    .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read), .o_ex_mem_write(ex_mem_write),
    .o_ex_mem_to_reg(ex_mem_to_reg), .o_ex_alu_src(ex_alu_src), .o_ex_alu_op(ex_alu_op),
    .o_ex_branch(ex_branch), .o_pc_write_en(pc_write_en), .o_if_id_write_en(if_id_write_en),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  id_ex_hazard_stage #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read), .i_id_mem_write(id_mem_write),
    .i_id_mem_to_reg(id_mem_to_reg), .i_id_alu_src(id_alu_src), .i_id_alu_op(id_alu_op),
    .i_id_branch(id_branch), .i_ex_flush(ex_flush), .i_wb_reg_write(wb_reg_write),
    .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_ex_valid(s_valid), .o_ex_pc(s_pc), .o_ex_rs1_data(s_rs1_data),
    .o_ex_rs2_data(s_rs2_data), .o_ex_imm(s_imm), .o_ex_rs1(s_rs1), .o_ex_rs2(s_rs2),
    .o_ex_rd(s_rd), .o_ex_uses_rs1(s_uses_rs1), .o_ex_uses_rs2(s_uses_rs2),
    .o_ex_reg_write(s_reg_write), .o_ex_mem_read(s_mem_read), .o_ex_mem_write(s_mem_write),
    .o_ex_mem_to_reg(s_mem_to_reg), .o_ex_alu_src(s_alu_src), .o_ex_alu_op(s_alu_op),
    .o_ex_branch(s_branch), .o_pc_write_en(s_pc_we), .o_if_id_write_en(s_ifid_we),
    .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_alu_src = 0; id_alu_op = 0; id_branch = 0;
  endtask

  task automatic id_lw(input logic [4:0] rd, input logic [31:0] pc);
    id_idle();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = 5'd2; id_uses_rs1 = 1;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_imm = 32'h10;
  endtask

  task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [31:0] pc);
    id_idle();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = 1; id_alu_op = 4'h2;
    id_rs1_data = 32'h1111_0000; id_rs2_data = 32'h2222_0000;
  endtask

  initial begin
    id_idle();
    ex_flush = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;

    // Reset with random ID contents
    reset = 1;
    id_valid = 1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
    id_branch = 1; id_alu_op = 4'($urandom);
    #1;
    chk("rst_pc_we_pre", 32'(pc_write_en), 32'd1);
    tick();
    tick();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_rs1_data", ex_rs1_data, 32'd0);
    chk("rst_rd", 32'(ex_rd), 32'd0);
    chk("rst_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src}, 32'd0);
    chk("rst_alu_op", 32'(ex_alu_op), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_pc_we", 32'(pc_write_en), 32'd1);
    chk("rst_ifid_we", 32'(if_id_write_en), 32'd1);
    reset = 0;
    id_idle();
    tick();

    // Load-use: lw x5 then add x6,x5,x7
    id_lw(5'd5, 32'h100);
    tick();
    chk("lw_in_ex_mr", 32'(ex_mem_read), 32'd1);
    chk("lw_in_ex_rd", 32'(ex_rd), 32'd5);
    id_add(5'd6, 5'd5, 5'd7, 1, 1, 32'h104);
    #1;
    chk("lu_pc_we", 32'(pc_write_en), 32'd0);
    chk("lu_ifid_we", 32'(if_id_write_en), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
    chk("lu_bubble_rd", 32'(ex_rd), 32'd0);
    chk("lu_bubble_pc_hold", ex_pc, 32'h100);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_pc_we_after", 32'(pc_write_en), 32'd1);
    tick();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rs1", 32'(ex_rs1), 32'd5);
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    chk("lu_add_pc", ex_pc, 32'h104);
    chk("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);

    // No stall when lw targets x0
    id_lw(5'd0, 32'h200);
    tick();
    id_add(5'd6, 5'd0, 5'd7, 1, 1, 32'h204);
    #1;
    chk("x0_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk("x0_add_valid", 32'(ex_valid), 32'd1);
    chk("x0_add_pc", ex_pc, 32'h204);

    // No stall when ID does not read the matching register
    id_lw(5'd5, 32'h300);
    tick();
    id_add(5'd6, 5'd5, 5'd5, 0, 0, 32'h304);
    #1;
    chk("nouse_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk("nouse_add_pc", ex_pc, 32'h304);
    chk("nouse_stall_cnt", 32'(stall_cnt), 32'd1);

    // Flush coinciding with a load-use: flush wins
    id_lw(5'd5, 32'h400);
    tick();
    id_add(5'd6, 5'd5, 5'd7, 1, 0, 32'h404);
    ex_flush = 1;
    #1;
    chk("fl_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    ex_flush = 0;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("fl_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("fl_pc_hold", ex_pc, 32'h400);

    // WB bypass into captured operands
    id_idle();
    id_valid = 1; id_rs1 = 5'd4; id_rs1_data = 32'h1234; id_rs2 = 5'd3; id_rs2_data = 0;
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    chk("byp_rs2", ex_rs2_data, 32'hDEADBEEF);
    chk("byp_rs1_none", ex_rs1_data, 32'h1234);
    id_rs2 = 5'd0; wb_rd = 5'd0;
    tick();
    chk("byp_x0", ex_rs2_data, 32'd0);
    wb_reg_write = 0; wb_rd = 5'd3; id_rs2 = 5'd3; id_rs2_data = 32'h55;
    tick();
    chk("byp_no_we", ex_rs2_data, 32'h55);
    wb_data = 0; wb_rd = 0;

    // Twenty more stalls: 16-bit counter reaches 21, 4-bit counter pins at 15
    for (int i = 0; i < 20; i++) begin
      id_lw(5'd9, 32'h1000 + 32'(i * 8));
      tick();
      id_add(5'd10, 5'd1, 5'd9, 0, 1, 32'h1004 + 32'(i * 8));
      tick();
      tick();
      if (i == 13) chk("sat_reach15", 32'(s_stall_cnt), 32'd15);
    end
    chk("sat_stall4", 32'(s_stall_cnt), 32'd15);
    chk("sat_stall16", 32'(stall_cnt), 32'd21);
    chk("sat_flush4", 32'(s_flush_cnt), 32'd1);

    // Reset arriving during a stall
    id_lw(5'd5, 32'h500);
    tick();
    id_add(5'd6, 5'd5, 5'd7, 1, 1, 32'h504);
    #1;
    chk("rm_pc_we_stall", 32'(pc_write_en), 32'd0);
    reset = 1;
    #1;
    chk("rm_pc_we_rst", 32'(pc_write_en), 32'd1);
    tick();
    reset = 0;
    #1;
    chk("rm_valid", 32'(ex_valid), 32'd0);
    chk("rm_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rm_pc_we_after", 32'(pc_write_en), 32'd1);
    tick();
    chk("rm_add_loads", ex_pc, 32'h504);
    chk("rm_add_valid", 32'(ex_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
